cla_sub_seq: RTL

CLA_SUB_SEQ -- requirements
Module: cla_sub_seq

---
 rtl/cla_sub_seq_pkg.sv | 17 +
 rtl/lookahead_sub4.sv | 29 ++
 rtl/cla_sub_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/cla_sub_seq_pkg.sv
// Shared definitions for the nibble-serial borrow-lookahead subtractor.
package cla_sub_seq_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits processed per BUSY cycle
    localparam int NIBBLE = 4;

    // Default operand width
    localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/lookahead_sub4.sv
// 4-bit subtractor slice with fully expanded borrow lookahead (no ripple chain).
module lookahead_sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms and flattened borrow equations for every bit
    always_comb begin
        g = ~a & b;
        p = ~(a ^ b);
        c[0] = bin;
        c[1] = g[0] | (p[0] & bin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & bin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);
        d    = a ^ b ^ c[3:0];
        bout = c[4];
    end

endmodule

// File: rtl/cla_sub_seq.sv
// Sequential subtractor: computes A - B - Bin one nibble per cycle (LSB first),
// chaining the registered borrow between nibbles, with a valid/ready handshake.
module cla_sub_seq
    import cla_sub_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    localparam int NIB_N = WIDTH / NIBBLE;
    localparam int IDX_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB_N - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             brw_q;
    logic [IDX_W-1:0] idx;

    logic [NIBBLE-1:0] nib_a;
    logic [NIBBLE-1:0] nib_b;
    logic [NIBBLE-1:0] nib_d;
    logic              nib_bout;

    // Select the operand nibbles addressed by the current index
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIB_N; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_a = a_q[i*NIBBLE +: NIBBLE];
                nib_b = b_q[i*NIBBLE +: NIBBLE];
            end
        end
    end

    lookahead_sub4 u_sub4 (
        .a    (nib_a),
        .b    (nib_b),
        .bin  (brw_q),
        .d    (nib_d),
        .bout (nib_bout)
    );

    // Controller, operand capture, nibble accumulation and registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            brw_q     <= 1'b0;
            idx       <= '0;
            Diff      <= '0;
            Bout      <= 1'b0;
            Ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        brw_q    <= Bin;
                        idx      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < NIB_N; i++) begin
                        if (idx == IDX_W'(i)) begin
                            Diff[i*NIBBLE +: NIBBLE] <= nib_d;
                        end
                    end
                    brw_q <= nib_bout;
                    if (idx == IDX_LAST) begin
                        // Top nibble just produced: its MSB is the result sign
                        state     <= DONE;
                        out_valid <= 1'b1;
                        Bout      <= nib_bout;
                        Ovf       <= (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                                   & (nib_d[NIBBLE-1] ^ a_q[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
